// File: rtl/fir_pkg.sv
// Shared parameters, FSM state type and output saturation helper for the
// 64-tap Q1.15 FIR multiply-accumulate core.
package fir_pkg;

  localparam int TAPS = 64;
  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int ACCW = 38;

  localparam logic [DW-1:0] SAT_MAX  = 16'h7FFF;
  localparam logic [DW-1:0] SAT_MIN  = 16'h8000;
  localparam logic [AW:0]   MAC_LAST = 7'd64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Rescale a Q2.30-style sum back to Q1.15 by truncation, clamping on overflow.
  function automatic logic [DW-1:0] sat_q15(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] shifted;
    logic [ACCW-DW:0]       upper;
    shifted = acc >>> (DW - 1);
    upper   = shifted[ACCW-1:DW-1];
    if ((&upper) || !(|upper)) begin
      sat_q15 = shifted[DW-1:0];
    end else if (shifted[ACCW-1]) begin
      sat_q15 = SAT_MIN;
    end else begin
      sat_q15 = SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/fir_mac_core_if.sv
// Coefficient load, sample handshake and result bus of the FIR core.
interface fir_mac_core_if;
  import fir_pkg::*;

  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [DW-1:0] coef_wdata;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          sample_ready;
  logic          busy;
  logic [DW-1:0] result;
  logic          result_valid;

  modport master (
    output coef_we, coef_addr, coef_wdata, sample_valid, sample_data,
    input  sample_ready, busy, result, result_valid
  );

  modport slave (
    input  coef_we, coef_addr, coef_wdata, sample_valid, sample_data,
    output sample_ready, busy, result, result_valid
  );

endinterface

// File: rtl/fir_tap_buffer.sv
// Circular sample history; the read port is addressed by age, 0 = newest sample.
module fir_tap_buffer
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] rd_ofs_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] hist_q [TAPS];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rd_idx_s;

  // The newest sample sits one slot behind the write pointer; 6-bit math wraps mod 64.
  assign rd_idx_s  = wptr_q - AW'(1'b1) - rd_ofs_i;
  assign rd_data_o = hist_q[rd_idx_s];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
      end
      wptr_q <= '0;
    end else if (we_i) begin
      hist_q[wptr_q] <= wdata_i;
      wptr_q         <= wptr_q + AW'(1'b1);
    end
  end

endmodule

// File: rtl/fir_mac_core.sv
// 64-tap FIR: coefficient file, sequential MAC with a registered product stage,
// and a three-state controller producing one saturated result per sample.
module fir_mac_core
  import fir_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fir_mac_core_if.slave  bus
);

  state_e                 state_q, state_d;
  logic [DW-1:0]          coef_q [TAPS];
  logic [AW:0]            cnt_q;
  logic signed [2*DW-1:0] prod_q, prod_s;
  logic signed [ACCW-1:0] acc_q, prod_ext_s;
  logic [DW-1:0]          result_q;
  logic                   result_valid_q, busy_q, ready_q;
  logic                   accept_s;
  logic [DW-1:0]          coef_rd_s, hist_rd_s;

  assign accept_s   = bus.sample_valid & ready_q;
  assign coef_rd_s  = coef_q[cnt_q[AW-1:0]];
  assign prod_s     = $signed(coef_rd_s) * $signed(hist_rd_s);
  assign prod_ext_s = {{(ACCW-2*DW){prod_q[2*DW-1]}}, prod_q};

  fir_tap_buffer u_taps (
    .clk       (clk),
    .reset     (reset),
    .we_i      (accept_s),
    .wdata_i   (bus.sample_data),
    .rd_ofs_i  (cnt_q[AW-1:0]),
    .rd_data_o (hist_rd_s)
  );

  // Coefficients are frozen while a convolution is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (bus.coef_we && !busy_q) begin
      coef_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        if (cnt_q == MAC_LAST) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The product for tap i is added one cycle later, so MAC spans 65 edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      prod_q         <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b1;
    end else begin
      result_valid_q <= 1'b0;
      busy_q         <= (state_d != IDLE);
      ready_q        <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            cnt_q <= '0;
            acc_q <= '0;
          end
        end
        MAC: begin
          prod_q <= prod_s;
          cnt_q  <= cnt_q + (AW+1)'(1'b1);
          if (cnt_q != '0) begin
            acc_q <= acc_q + prod_ext_s;
          end
        end
        DONE: begin
          result_q       <= sat_q15(acc_q);
          result_valid_q <= 1'b1;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench: random and directed stimulus against a queue-based
// convolution model of the FIR core.
module tb_fir_mac_core;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_mac_core_if bus ();

  fir_mac_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int coef_m [TAPS];
  int hist_m [$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (coef_m[i]) coef_m[i] = 0;
    hist_m.delete();
  endtask

  task automatic model_push(input logic [15:0] x);
    hist_m.push_front(int'($signed(x)));
    if (hist_m.size() > TAPS) void'(hist_m.pop_back());
  endtask

  function automatic logic [15:0] model_out();
    longint acc = 0;
    for (int i = 0; i < hist_m.size(); i++) begin
      acc += longint'(coef_m[i]) * longint'(hist_m[i]);
    end
    acc = acc >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.coef_we = 1'b0;
    bus.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_coef(input int addr, input logic [15:0] val);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 6'(addr);
    bus.coef_wdata = val;
    @(negedge clk);
    bus.coef_we = 1'b0;
    coef_m[addr] = int'($signed(val));
  endtask

  task automatic send_sample(input logic [15:0] x, output logic [15:0] got);
    int n = 0;
    check("rdy", bus.sample_ready, 1);
    bus.sample_valid = 1'b1;
    bus.sample_data  = x;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    model_push(x);
    check("busy", bus.busy, 1);
    while (!bus.result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lat", n, 66);
    check("res", bus.result, model_out());
    check("bsy0", bus.busy, 0);
    got = bus.result;
    @(negedge clk);
    check("pulse", bus.result_valid, 0);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] exp_q [$];
    int last_acc, n_acc, n, saw_rv;

    reset = 1'b0;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_res", bus.result, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdy", bus.sample_ready, 1);
    send_sample(16'h4000, got);
    check("zero_coef", got, 16'h0000);

    // single tap
    do_reset();
    write_coef(0, 16'h4000);
    send_sample(16'h2000, got);
    check("single", got, 16'h1000);

    // impulse response and wrap-around
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'(i * 256));
    for (int m = 0; m < TAPS; m++) begin
      send_sample((m == 0) ? 16'h4000 : 16'h0000, got);
      check("impulse", got, 16'(m * 128));
    end
    send_sample(16'h0000, got);
    check("wrap", got, 16'h0000);

    // saturation both directions
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'h7FFF);
    for (int m = 0; m < TAPS; m++) send_sample(16'h7FFF, got);
    check("sat_pos", got, 16'h7FFF);
    for (int m = 0; m < TAPS; m++) send_sample(16'h8000, got);
    check("sat_neg", got, 16'h8000);

    // handshake: continuous valid, coefficient write attempted while busy
    do_reset();
    write_coef(0, 16'h4000);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'h2000;
    last_acc = -1;
    n_acc = 0;
    for (int c = 0; c < 150; c++) begin
      if (c == 10) begin
        bus.coef_we = 1'b1; bus.coef_addr = 6'd0; bus.coef_wdata = 16'h7FFF;
      end else begin
        bus.coef_we = 1'b0;
      end
      if (bus.result_valid) begin
        if (exp_q.size() > 0) check("hs_res", bus.result, exp_q.pop_front());
        else check("hs_extra", 1, 0);
      end
      if (bus.sample_ready) begin
        model_push(16'h2000);
        exp_q.push_back(model_out());
        if (last_acc >= 0) check("hs_gap", c - last_acc, 67);
        last_acc = c;
        n_acc++;
      end
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
    bus.coef_we = 1'b0;
    check("hs_cnt", n_acc, 3);
    n = 0;
    while (!bus.result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hs_last_seen", bus.result_valid, 1);
    check("hs_last", bus.result, 16'h1000);

    // reset in the middle of a convolution
    do_reset();
    write_coef(0, 16'h4000);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'h2000;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    saw_rv = 0;
    repeat (29) begin
      @(negedge clk);
      if (bus.result_valid) saw_rv = 1;
    end
    #2 reset = 1'b0;
    #1;
    check("mr_rv_seen", saw_rv, 0);
    check("mr_rv", bus.result_valid, 0);
    check("mr_res", bus.result, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_rdy", bus.sample_ready, 1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_sample(16'h2000, got);
    check("mr_coef_clr", got, 16'h0000);
    write_coef(0, 16'h4000);
    send_sample(16'h2000, got);
    check("mr_single", got, 16'h1000);

    // random coefficients and samples
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, 16'($urandom));
    for (int s = 0; s < 80; s++) send_sample(16'($urandom), got);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
